// File: rtl/fft16_ctrl_pkg.sv
// Shared types and constants for the 16-point radix-4 FFT controller.
// The bus carries four complex lanes; each lane is Re(17) in the upper half and Im(17) in the lower half.
package fft16_ctrl_pkg;

  localparam int CPLX_W = 34;
  localparam int LANES  = 4;
  localparam int BUS_W  = LANES * CPLX_W;

  typedef enum logic [1:0] {
    S1    = 2'd0,
    S2    = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // MSB of the butterfly rotation selects the stage.
  localparam logic ROT_S1 = 1'b0;
  localparam logic ROT_S2 = 1'b1;

  function automatic logic [CPLX_W-1:0] lane_of(input logic [BUS_W-1:0] grp,
                                                input logic [1:0]       idx);
    return grp[32'(idx) * CPLX_W +: CPLX_W];
  endfunction

endpackage

// File: rtl/fft16_tbuf.sv
// 4x136 transpose buffer: rows are written whole, reads gather one lane from every row.
module fft16_tbuf
  import fft16_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [1:0]       wr_idx_i,
  input  logic [BUS_W-1:0] wr_data_i,
  input  logic [1:0]       rd_lane_i,
  output logic [BUS_W-1:0] rd_data_o
);

  logic [BUS_W-1:0] mem_q [LANES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Output lane r comes from row r, so stage-2 input k is stage-1 group k.
  always_comb begin
    rd_data_o = '0;
    for (int r = 0; r < LANES; r++) begin
      rd_data_o[r*CPLX_W +: CPLX_W] = lane_of(mem_q[r], rd_lane_i);
    end
  end

endmodule

// File: rtl/fft16_ctrl.sv
// Sequencer driving one radix-4 butterfly through both stages of a 16-point FFT frame.
// Optional build macro FFT16_CTRL_FRAME_CNT_EN adds the frame_cnt output.
module fft16_ctrl
  import fft16_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BUS_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BUS_W-1:0] out_data,
  output logic [1:0]       out_idx,
  output logic             out_last,
  output logic             busy,
  output logic [BUS_W-1:0] bf_calc_in,
  output logic [2:0]       bf_rotation,
  input  logic [BUS_W-1:0] bf_calc_out
`ifdef FFT16_CTRL_FRAME_CNT_EN
  ,
  output logic [7:0]       frame_cnt
`endif
);

  state_e           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [BUS_W-1:0] out_data_q, out_data_d;
  logic [1:0]       out_idx_q, out_idx_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;

  logic             in_accept;
  logic             slot_free;
  logic             out_accept;
  logic [BUS_W-1:0] tbuf_rd;

  assign in_ready   = (state_q == S1);
  assign in_accept  = in_ready && in_valid;
  assign slot_free  = !out_valid_q || out_ready;
  assign out_accept = out_valid_q && out_ready;

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_idx    = out_idx_q;
  assign out_last   = out_last_q;
  assign busy       = busy_q;

  fft16_tbuf u_tbuf (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (in_accept),
    .wr_idx_i  (cnt_q),
    .wr_data_i (bf_calc_out),
    .rd_lane_i (cnt_q),
    .rd_data_o (tbuf_rd)
  );

  always_comb begin
    bf_calc_in  = '0;
    bf_rotation = '0;
    case (state_q)
      S1: begin
        bf_calc_in  = in_data;
        bf_rotation = {ROT_S1, cnt_q};
      end
      S2: begin
        bf_calc_in  = tbuf_rd;
        bf_rotation = {ROT_S2, cnt_q};
      end
      default: begin
        bf_calc_in  = '0;
        bf_rotation = '0;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_idx_d   = out_idx_q;
    out_last_d  = out_last_q;
    busy_d      = busy_q;
    case (state_q)
      S1: begin
        if (in_valid) begin
          cnt_d  = 2'(cnt_q + 2'd1);
          busy_d = 1'b1;
          if (cnt_q == 2'd3) state_d = S2;
        end
      end
      S2: begin
        // A result may load in the same cycle the previous one is taken.
        if (slot_free) begin
          out_data_d  = bf_calc_out;
          out_idx_d   = cnt_q;
          out_last_d  = (cnt_q == 2'd3);
          out_valid_d = 1'b1;
          cnt_d       = 2'(cnt_q + 2'd1);
          if (cnt_q == 2'd3) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_accept) begin
          out_valid_d = 1'b0;
          cnt_d       = 2'd0;
          busy_d      = 1'b0;
          state_d     = S1;
        end
      end
      default: begin
        state_d = S1;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S1;
      cnt_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_idx_q   <= 2'd0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_idx_q   <= out_idx_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

`ifdef FFT16_CTRL_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= 8'd0;
    end else if (out_accept && out_last_q) begin
      frame_cnt_q <= 8'(frame_cnt_q + 8'd1);
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_fft16_ctrl.sv
// Scoreboard bench for fft16_ctrl with a behavioural radix-4 butterfly attached to the bf_* ports.
module tb_fft16_ctrl;

  localparam int CW = 34;
  localparam int BW = 136;
  localparam int COS_T [10] = '{256, 237, 181, 98, 0, -98, -181, -237, -256, -237};
  localparam int SIN_T [10] = '{0, 98, 181, 237, 256, 237, 181, 98, 0, -98};

  typedef struct packed {
    logic [BW-1:0] d;
    logic [1:0]    idx;
    logic          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [BW-1:0] out_data;
  logic [1:0]    out_idx;
  logic          out_last;
  logic          busy;
  logic [BW-1:0] bf_calc_in;
  logic [2:0]    bf_rotation;
  logic [BW-1:0] bf_calc_out;
`ifdef FFT16_CTRL_FRAME_CNT_EN
  logic [7:0]    frame_cnt;
`endif

  int   total = 0;
  int   bad = 0;
  int   frames_pushed = 0;
  int   frames_done = 0;
  int   rdy_mode = 0;
  int   stall_left = 0;
  exp_t sb_q [$];
  logic [BW-1:0] fr [4];

  always #5 clk = ~clk;

  fft16_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .busy        (busy),
    .bf_calc_in  (bf_calc_in),
    .bf_rotation (bf_rotation),
    .bf_calc_out (bf_calc_out)
`ifdef FFT16_CTRL_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  // Radix-4 DFT over the lanes; stage-1 rotations r also apply twiddle W16^(r*q) to output q.
  function automatic logic [BW-1:0] bf_model(input logic [BW-1:0] din, input logic [2:0] rot);
    int re [4];
    int im [4];
    int yr, yi, n, pr, pm;
    logic signed [16:0] t;
    logic [BW-1:0] r;
    r = '0;
    for (int m = 0; m < 4; m++) begin
      t = din[m*CW+17 +: 17];
      re[m] = int'(t);
      t = din[m*CW +: 17];
      im[m] = int'(t);
    end
    for (int q = 0; q < 4; q++) begin
      yr = 0;
      yi = 0;
      for (int m = 0; m < 4; m++) begin
        n = (m * q) % 4;
        case (n)
          0: begin yr += re[m]; yi += im[m]; end
          1: begin yr += im[m]; yi -= re[m]; end
          2: begin yr -= re[m]; yi -= im[m]; end
          default: begin yr -= im[m]; yi += re[m]; end
        endcase
      end
      if (!rot[2]) begin
        n  = int'(rot[1:0]) * q;
        pr = (yr * COS_T[n] + yi * SIN_T[n]) >>> 8;
        pm = (yi * COS_T[n] - yr * SIN_T[n]) >>> 8;
        yr = pr;
        yi = pm;
      end
      r[q*CW+17 +: 17] = 17'(yr);
      r[q*CW +: 17]    = 17'(yi);
    end
    return r;
  endfunction

  always_comb bf_calc_out = bf_model(bf_calc_in, bf_rotation);

  function automatic logic [BW-1:0] rand_bus();
    logic [BW-1:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = $urandom;
    r[135:128] = 8'($urandom);
    return r;
  endfunction

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic make_random();
    for (int k = 0; k < 4; k++)
      for (int l = 0; l < 4; l++) fr[k][l*CW +: CW] = {17'($urandom), 17'($urandom)};
  endtask

  task automatic make_impulse();
    for (int k = 0; k < 4; k++) fr[k] = '0;
    fr[0][CW-1:0] = {17'd256, 17'd0};
  endtask

  task automatic make_dc();
    for (int k = 0; k < 4; k++)
      for (int l = 0; l < 4; l++) fr[k][l*CW +: CW] = {17'd256, 17'd0};
  endtask

  // mode 0: two-stage dataflow through the reference butterfly; 1: impulse answer; 2: DC answer.
  task automatic push_expected(input int mode);
    logic [BW-1:0] t [4];
    logic [BW-1:0] x;
    exp_t e;
    for (int k = 0; k < 4; k++) t[k] = bf_model(fr[k], {1'b0, 2'(k)});
    for (int j = 0; j < 4; j++) begin
      e.d = '0;
      if (mode == 0) begin
        x = '0;
        for (int k = 0; k < 4; k++) x[k*CW +: CW] = t[k][j*CW +: CW];
        e.d = bf_model(x, {1'b1, 2'(j)});
      end else if (mode == 1) begin
        for (int k = 0; k < 4; k++) e.d[k*CW +: CW] = {17'd256, 17'd0};
      end else if (j == 0) begin
        e.d[CW-1:0] = {17'd4096, 17'd0};
      end
      e.idx  = 2'(j);
      e.last = (j == 3);
      sb_q.push_back(e);
    end
    frames_pushed++;
  endtask

  // Called at posedge+1; garbage is presented with in_valid while the DUT is not ready.
  task automatic send_frame(input int mode, input bit garb, input int nbeats);
    int n;
    for (int k = 0; k < nbeats; k++) begin
      n = 0;
      while (!in_ready) begin
        in_valid = garb;
        in_data  = rand_bus();
        @(posedge clk);
        #1;
        n++;
        if (n > 300) begin
          total++;
          bad++;
          $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles expected 1", n);
          in_valid = 1'b0;
          return;
        end
      end
      in_valid = 1'b1;
      in_data  = fr[k];
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (nbeats == 4) push_expected(mode);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    in_valid = 1'b0;
    while ((frames_pushed != frames_done || out_valid) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_outstanding", BW'(frames_pushed - frames_done), '0);
    check("drain_queue", BW'(sb_q.size()), '0);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        default: begin
          if (out_valid && out_idx == 2'd1 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            out_ready = 1'b1;
          end
        end
      endcase
    end
  end

  initial begin
    exp_t e;
    bit stall_prev;
    stall_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (stall_prev) check("hold_valid", BW'(out_valid), BW'(1));
        stall_prev = out_valid && !out_ready;
        if (frames_pushed != frames_done) begin
          check("in_ready_low", BW'(in_ready), '0);
          check("busy_high", BW'(busy), BW'(1));
        end
        if (out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_beat: got idx %0d expected no beat", out_idx);
          end else begin
            e = sb_q.pop_front();
            check("out_data", out_data, e.d);
            check("out_idx", BW'(out_idx), BW'(e.idx));
            check("out_last", BW'(out_last), BW'(e.last));
            if (e.last) frames_done++;
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", BW'(in_ready), BW'(1));
    check("rst_out_valid", BW'(out_valid), '0);
    check("rst_busy", BW'(busy), '0);
    check("rst_out_data", out_data, '0);
    check("rst_out_idx", BW'(out_idx), '0);
    check("rst_out_last", BW'(out_last), '0);
`ifdef FFT16_CTRL_FRAME_CNT_EN
    check("rst_frame_cnt", BW'(frame_cnt), '0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    make_impulse();
    send_frame(1, 1'b0, 4);
    wait_idle();

    make_dc();
    send_frame(2, 1'b0, 4);
    wait_idle();

    rdy_mode = 1;
    for (int i = 0; i < 6; i++) begin
      make_random();
      send_frame(0, 1'(i % 2), 4);
    end
    wait_idle();

    rdy_mode = 2;
    stall_left = 5;
    make_random();
    send_frame(0, 1'b0, 4);
    wait_idle();
    check("stall_used", BW'(stall_left), '0);

    rdy_mode = 0;
    make_random();
    send_frame(0, 1'b0, 4);
    make_impulse();
    send_frame(1, 1'b1, 4);
    wait_idle();

    make_random();
    send_frame(0, 1'b0, 2);
    check("partial_busy", BW'(busy), BW'(1));
    #2;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", BW'(in_ready), BW'(1));
    check("midrst_busy", BW'(busy), '0);
    check("midrst_out_valid", BW'(out_valid), '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    make_impulse();
    send_frame(1, 1'b0, 4);
    wait_idle();

`ifdef FFT16_CTRL_FRAME_CNT_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("cnt_after_rst", BW'(frame_cnt), '0);
    for (int i = 0; i < 257; i++) begin
      make_random();
      send_frame(0, 1'b0, 4);
    end
    wait_idle();
    check("frame_cnt_wrap", BW'(frame_cnt), BW'(1));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
